// File: rtl/aes_block_feeder_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : aes_block_feeder_if
// Brief    : Word-stream input and AES_top drive/return signals of the feeder.
// Revision : 1.0 - initial release
// ============================================================================
interface aes_block_feeder_if #(
    parameter int WORD_W = 32
);
    logic [WORD_W-1:0]   s_word;
    logic                s_valid;
    logic                s_ready;
    logic [4*WORD_W-1:0] key_in;
    logic                aes_en;
    logic [4*WORD_W-1:0] aes_data;
    logic [4*WORD_W-1:0] aes_key;
    logic                aes_done;

    // master: word source plus AES core; slave: the feeder itself
    modport master (
        output s_word, s_valid, key_in, aes_done,
        input  s_ready, aes_en, aes_data, aes_key
    );

    modport slave (
        input  s_word, s_valid, key_in, aes_done,
        output s_ready, aes_en, aes_data, aes_key
    );
endinterface
`default_nettype wire

// File: rtl/aes_block_feeder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : aes_block_feeder
// Brief    : Packs four 32-bit words into a 128-bit block and runs it through
//            AES_top with a post-block idle gap and a hung-core timeout.
// Revision : 1.0 - initial release
// ============================================================================
module aes_block_feeder #(
    parameter int WORD_W      = 32,
    parameter int GAP_CYCLES  = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  wire logic          AES_clk,
    input  wire logic          AES_rst,
    aes_block_feeder_if.slave  bus,
    output logic               busy,
    output logic               timeout_err,
    output logic [15:0]        blk_cnt
);
    localparam int c_BLK_W = 4 * WORD_W;
    localparam int c_RUN_W = $clog2(TIMEOUT_CYC + 1);
    localparam int c_GAP_W = $clog2(GAP_CYCLES + 1);

    localparam logic [c_RUN_W-1:0] c_RUN_LAST = c_RUN_W'(TIMEOUT_CYC - 1);
    localparam logic [c_GAP_W-1:0] c_GAP_LOAD = c_GAP_W'(GAP_CYCLES - 1);

    localparam logic [1:0] S_FILL = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         r_word_cnt;
    logic [c_GAP_W-1:0] r_gap_cnt;
    logic [c_RUN_W-1:0] r_run_cnt;
    logic               r_en;
    logic [c_BLK_W-1:0] r_data;
    logic [c_BLK_W-1:0] r_key;
    logic               r_timeout;
    logic [15:0]        r_blk_cnt;

    logic w_ready;
    logic w_hs;

    assign w_ready = (r_state == S_FILL);
    assign w_hs    = bus.s_valid && w_ready;

    always_ff @(posedge AES_clk) begin
        if (AES_rst) begin
            r_state    <= S_FILL;
            r_word_cnt <= '0;
            r_gap_cnt  <= '0;
            r_run_cnt  <= '0;
            r_en       <= 1'b0;
            r_data     <= '0;
            r_key      <= '0;
            r_timeout  <= 1'b0;
            r_blk_cnt  <= '0;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (w_hs) begin
                        // Oldest word shifts toward the MSBs; the 2-bit count wraps 3->0.
                        r_data     <= {r_data[3*WORD_W-1:0], bus.s_word};
                        r_word_cnt <= r_word_cnt + 2'd1;
                        if (r_word_cnt == 2'd3) begin
                            r_key     <= bus.key_in;
                            r_en      <= 1'b1;
                            r_run_cnt <= '0;
                            r_state   <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_run_cnt <= r_run_cnt + 1'b1;
                    // Done takes priority over a timeout landing on the same cycle.
                    if (bus.aes_done) begin
                        r_en      <= 1'b0;
                        r_blk_cnt <= r_blk_cnt + 16'd1;
                        r_gap_cnt <= c_GAP_LOAD;
                        r_state   <= S_GAP;
                    end else if (r_run_cnt == c_RUN_LAST) begin
                        r_en      <= 1'b0;
                        r_timeout <= 1'b1;
                        r_gap_cnt <= c_GAP_LOAD;
                        r_state   <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == '0) begin
                        r_state <= S_FILL;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end
                end
                default: r_state <= S_FILL;
            endcase
        end
    end

    assign bus.s_ready  = w_ready;
    assign bus.aes_en   = r_en;
    assign bus.aes_data = r_data;
    assign bus.aes_key  = r_key;
    assign busy         = (r_state != S_FILL);
    assign timeout_err  = r_timeout;
    assign blk_cnt      = r_blk_cnt;

endmodule
`default_nettype wire

// File: tb/tb_aes_block_feeder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_aes_block_feeder
// Brief    : Directed plus randomized bench for aes_block_feeder with a
//            word-history reference model and a behavioural AES-core stand-in.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_block_feeder;
    localparam int c_GAP = 2;
    localparam int c_TMO = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        busy;
    logic        timeout_err;
    logic [15:0] blk_cnt;

    aes_block_feeder_if #(.WORD_W(32)) bus();

    aes_block_feeder #(
        .WORD_W     (32),
        .GAP_CYCLES (c_GAP),
        .TIMEOUT_CYC(c_TMO)
    ) dut (
        .AES_clk    (clk),
        .AES_rst    (rst),
        .bus        (bus.slave),
        .busy       (busy),
        .timeout_err(timeout_err),
        .blk_cnt    (blk_cnt)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] hist[$];
    logic [31:0] blk_w[4];
    int          m_blk = 0;
    logic        m_err = 1'b0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected block: the last four words accepted since reset, oldest at the MSBs.
    function automatic logic [127:0] last_block();
        int n = hist.size();
        if (n < 4) return '0;
        return {hist[n-4], hist[n-3], hist[n-2], hist[n-1]};
    endfunction

    // Starts and ends just after a falling edge.
    task automatic send_words(input int n, input bit toggle, input bit stray);
        int   k  = 0;
        int   it = 0;
        logic rdy;
        while (k < n && it < 64) begin
            bus.s_valid  = !toggle || (it % 2 == 0);
            bus.s_word   = blk_w[k];
            bus.aes_done = stray ? 1'($urandom_range(0, 1)) : 1'b0;
            rdy = bus.s_ready;
            @(posedge clk);
            if (bus.s_valid && rdy) begin
                hist.push_back(bus.s_word);
                k++;
            end
            it++;
            @(negedge clk);
        end
        bus.s_valid  = 1'b0;
        bus.aes_done = 1'b0;
        if (k < n) chk("fill_handshakes", 128'(k), 128'(n));
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        hist.delete();
        m_blk = 0;
        m_err = 1'b0;
    endtask

    // lat = cycle of aes_en-high in which the core model raises aes_done (0: never).
    task automatic do_block(input logic [127:0] key, input int lat, input bit toggle,
                            input bit stray, input bit hold_next, input logic [31:0] next_w);
        int   cyc = 0;
        int   gap = 0;
        int   exp_len;
        logic rdy_seen = 1'b0;
        logic en_in_gap = 1'b0;
        logic [127:0] exp_data;
        bus.key_in = key;
        send_words(4, toggle, stray);
        exp_data = last_block();
        chk("en_after_fill", 128'(bus.aes_en), 128'(1'b1));
        chk("data_after_fill", bus.aes_data, exp_data);
        chk("key_after_fill", bus.aes_key, key);
        bus.key_in = {$urandom(), $urandom(), $urandom(), $urandom()};
        if (hold_next) begin
            bus.s_valid = 1'b1;
            bus.s_word  = next_w;
        end
        while (bus.aes_en && cyc < 200) begin
            cyc++;
            rdy_seen |= bus.s_ready;
            bus.aes_done = (cyc == lat);
            @(negedge clk);
        end
        bus.aes_done = 1'b0;
        exp_len = (lat >= 1 && lat <= c_TMO) ? lat : c_TMO;
        if (lat >= 1 && lat <= c_TMO) m_blk++;
        else m_err = 1'b1;
        chk("en_high_cycles", 128'(cyc), 128'(exp_len));
        while (busy && gap < 50) begin
            gap++;
            rdy_seen  |= bus.s_ready;
            en_in_gap |= bus.aes_en;
            bus.aes_done = stray ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
        end
        bus.aes_done = 1'b0;
        chk("gap_cycles", 128'(gap), 128'(c_GAP));
        chk("en_in_gap", 128'(en_in_gap), 128'(1'b0));
        chk("ready_after_gap", 128'(bus.s_ready), 128'(1'b1));
        chk("blk_cnt", 128'(blk_cnt), 128'(m_blk[15:0]));
        chk("timeout_err", 128'(timeout_err), 128'(m_err));
        chk("data_retained", bus.aes_data, exp_data);
        chk("key_retained", bus.aes_key, key);
        if (hold_next) chk("ready_while_busy", 128'(rdy_seen), 128'(1'b0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] key;
        bus.s_word   = '0;
        bus.s_valid  = 1'b0;
        bus.key_in   = '0;
        bus.aes_done = 1'b0;

        // Reset and idle
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_aes_en", 128'(bus.aes_en), 128'(1'b0));
        chk("rst_aes_data", bus.aes_data, 128'd0);
        chk("rst_aes_key", bus.aes_key, 128'd0);
        chk("rst_busy", 128'(busy), 128'(1'b0));
        chk("rst_timeout", 128'(timeout_err), 128'(1'b0));
        chk("rst_blk_cnt", 128'(blk_cnt), 128'd0);
        chk("rst_s_ready", 128'(bus.s_ready), 128'(1'b1));

        // FIPS-197 vectors, done raised in the 21st enabled cycle
        key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        blk_w = '{32'h3243f6a8, 32'h885a308d, 32'h313198a2, 32'he0370734};
        do_block(key, 21, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("fips_block", last_block(), 128'h3243f6a8885a308d313198a2e0370734);

        // Backpressure with a fifth word held during RUN/GAP
        do_block(key, 21, 1'b1, 1'b0, 1'b1, 32'hcafe5a5a);
        blk_w = '{32'hcafe5a5a, $urandom(), $urandom(), $urandom()};
        do_block(key, 9, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("fifth_word_msb", 128'(bus.aes_data[127:96]), 128'(32'hcafe5a5a));

        // Timeout, then a normal block with the error still set
        blk_w = '{$urandom(), $urandom(), $urandom(), $urandom()};
        do_block({$urandom(), $urandom(), $urandom(), $urandom()}, 0, 1'b0, 1'b0, 1'b0, 32'h0);
        blk_w = '{$urandom(), $urandom(), $urandom(), $urandom()};
        do_block({$urandom(), $urandom(), $urandom(), $urandom()}, 5, 1'b1, 1'b0, 1'b0, 32'h0);

        // Done coincident with the timeout, stray done pulses in FILL/GAP
        reset_dut();
        blk_w = '{$urandom(), $urandom(), $urandom(), $urandom()};
        do_block({$urandom(), $urandom(), $urandom(), $urandom()}, c_TMO, 1'b0, 1'b1, 1'b0, 32'h0);

        // Randomized blocks, latencies straddling the timeout
        for (int i = 0; i < 10; i++) begin
            blk_w = '{$urandom(), $urandom(), $urandom(), $urandom()};
            do_block({$urandom(), $urandom(), $urandom(), $urandom()},
                     int'($urandom_range(1, 70)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'b0, 32'h0);
        end

        // Reset in the fifth RUN cycle
        blk_w = '{$urandom(), $urandom(), $urandom(), $urandom()};
        bus.key_in = {$urandom(), $urandom(), $urandom(), $urandom()};
        send_words(4, 1'b0, 1'b0);
        for (int i = 1; i < 5; i++) @(negedge clk);
        chk("en_before_reset", 128'(bus.aes_en), 128'(1'b1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrun_aes_en", 128'(bus.aes_en), 128'(1'b0));
        chk("midrun_aes_data", bus.aes_data, 128'd0);
        chk("midrun_blk_cnt", 128'(blk_cnt), 128'd0);
        chk("midrun_busy", 128'(busy), 128'(1'b0));
        chk("midrun_s_ready", 128'(bus.s_ready), 128'(1'b1));
        @(negedge clk);
        rst = 1'b0;
        hist.delete();
        m_blk = 0;
        m_err = 1'b0;

        // Partial fill abandoned by reset, then a fresh block packs from word 0
        blk_w = '{$urandom(), $urandom(), $urandom(), $urandom()};
        send_words(2, 1'b0, 1'b0);
        reset_dut();
        blk_w = '{$urandom(), $urandom(), $urandom(), $urandom()};
        do_block({$urandom(), $urandom(), $urandom(), $urandom()}, 7, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("fresh_block", bus.aes_data, {blk_w[0], blk_w[1], blk_w[2], blk_w[3]});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/aes_block_feeder.md
Name: aes_block_feeder

Overview:
- Upstream feeder for AES_top.
- Takes a 32-bit word stream over a valid/ready handshake and packs four words into one 128-bit plaintext block.
- Latches the 128-bit key, then drives AES_en/AES_data_in/AES_key_in with data held stable while aes_en is high.
- Waits for the core's output-valid, enforces an idle gap, then accepts the next block; a timeout guards against a hung core.

Parameters:
- WORD_W, 32: input word width; fixed at 32, since 4 words make 128 bits.
- GAP_CYCLES, 2: number of cycles aes_en stays low between blocks; minimum 1.
- TIMEOUT_CYC, 64: maximum number of RUN cycles to wait for aes_done before aborting.

Ports:
- AES_clk  in  1  clock; all logic is on the rising edge.
- AES_rst  in  1  synchronous, active-high reset.
- s_word  in  32  input word; the first word received becomes bits [127:96].
- s_valid  in  1  s_word is valid.
- s_ready  out  1  feeder can accept a word.
- key_in  in  128  key, sampled on the 4th word handshake.
- aes_en  out  1  connects to AES_top AES_en.
- aes_data  out  128  connects to AES_data_in.
- aes_key  out  128  connects to AES_key_in.
- aes_done  in  1  connects to AES_top AES_data_out_valid.
- busy  out  1  high in RUN or GAP.
- timeout_err  out  1  sticky abort flag.
- blk_cnt  out  16  count of completed blocks.

Behaviour:
- Reset (synchronous, AES_rst=1 at a rising edge):
  - state=FILL, word_cnt=0, gap_cnt=0, run_cnt=0.
  - aes_en=0, aes_data=0, aes_key=0, timeout_err=0, blk_cnt=0, busy=0.
  - Reset applies from any state; an in-flight block is discarded and aes_en drops on that same edge.
- States: FILL, RUN, GAP. s_ready=1 only in FILL; s_ready is a pure decode of state.
- FILL:
  - Handshake occurs when s_valid&s_ready at a rising edge.
  - On each handshake: aes_data <= {aes_data[95:0], s_word}; word_cnt <= word_cnt+1.
  - On the handshake with word_cnt==3:
    - word_cnt<=0, aes_key<=key_in, aes_en<=1, run_cnt<=0, state<=RUN.
    - aes_en is therefore high in the cycle after the 4th handshake, with aes_data and aes_key already final.
  - With s_valid=0, the state is held; no partial timeout applies in FILL.
- RUN:
  - aes_en=1; aes_data and aes_key are frozen; run_cnt increments each cycle.
  - If aes_done=1: aes_en<=0, blk_cnt<=blk_cnt+1 (wraps FFFF->0000), gap_cnt<=GAP_CYCLES-1, state<=GAP.
  - Else if run_cnt==TIMEOUT_CYC-1: aes_en<=0, timeout_err<=1, gap_cnt<=GAP_CYCLES-1, state<=GAP. blk_cnt is not incremented.
  - If aes_done and the timeout coincide, done wins: the block is counted and no error is raised.
- GAP:
  - aes_en=0; aes_done is ignored.
  - If gap_cnt==0, state<=FILL; else gap_cnt decrements.
  - aes_en is therefore low for exactly GAP_CYCLES cycles.
  - aes_data and aes_key retain their values until overwritten in FILL.
- aes_done outside RUN: ignored; it has no effect on any output.
- timeout_err is cleared only by AES_rst; operation continues normally after an abort.
- busy = (state!=FILL), registered-equivalent decode.
- Area: one 128-bit shift/hold register, one 128-bit key register, small counters.

Test Plan:
- Reset/idle: hold AES_rst=1 for 2 cycles, then release -> all outputs 0 except s_ready=1.
- Single block, FIPS-197 vectors:
  - Stimulus: key_in=2b7e151628aed2a6abf7158809cf4f3c; words 3243f6a8, 885a308d, 313198a2, e0370734 on consecutive cycles; bench model asserts aes_done 20 cycles after aes_en rises.
  - Required response: aes_data=3243f6a8885a308d313198a2e0370734 and aes_key=2b7e...4f3c in the cycle after the 4th handshake; aes_en high exactly 21 cycles; blk_cnt=1; aes_en low 2 cycles; then s_ready=1.
- Backpressure/gaps: s_valid toggles 1,0,1,0,... for the same 4 words, and a 5th word is presented during RUN -> packing is identical; the 5th word is not accepted (s_ready=0) until GAP ends; it then becomes bits [127:96] of block 2.
- Timeout: aes_done is never asserted -> aes_en is high exactly 64 cycles; timeout_err=1; blk_cnt unchanged; next block completes normally with timeout_err still 1.
- Coincidence/stray: aes_done asserted on run_cnt==63 -> blk_cnt increments and timeout_err=0; aes_done pulses during FILL and GAP -> no effect.
- Reset mid-RUN: AES_rst=1 at the 5th RUN cycle -> aes_en=0 on that edge; aes_data=0; blk_cnt=0; state FILL; a fresh 4-word block then packs from word 0.
